// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and image-format constants for program_loader
package loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CSUM_WIDTH = 8;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte-stream input and instruction-memory write port of program_loader
interface program_loader_if #(
  parameter int ADDR_WIDTH = 10
);

  logic                  in_valid;
  logic [7:0]            in_byte;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  // master: byte source and instruction memory; slave: the loader
  modport master (
    output in_valid, in_byte,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - packs four bytes MSB-first into a 32-bit word, pulsing word_valid the cycle after the 4th
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        word_end
);

  logic [1:0] cnt;

  assign word_end = shift_en && (cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else if (clear) begin
      cnt        <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_end;
      if (shift_en) begin
        word <= {word[23:0], data};
        cnt  <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader writing a length-prefixed byte image into imem; LOADER_CHECKSUM_EN adds a trailing checksum byte
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reload,
  program_loader_if.slave  bus,
  output logic             core_rst,
  output logic             done,
  output logic             error
);

  localparam logic [16:0] CAPACITY = 17'(1 << ADDR_WIDTH);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t ST_TAIL = ST_CSUM;
`else
  localparam state_t ST_TAIL = ST_DONE;
`endif

  state_t                state, state_next;
  logic [15:0]           len;
  logic [16:0]           words_done;
  logic [16:0]           len_now;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  accept;
  logic                  shift_en;
  logic                  word_end;
  logic                  last_word;
  logic                  csum_ok;

  assign bus.in_ready = !rst && !reload &&
                        (state inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM});
  assign accept    = bus.in_valid && bus.in_ready;
  assign shift_en  = accept && (state == ST_DATA);
  assign len_now   = {1'b0, len[15:8], bus.in_byte};
  assign last_word = (words_done + 17'd1) == {1'b0, len};

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload),
    .shift_en   (shift_en),
    .data       (bus.in_byte),
    .word       (bus.imem_wdata),
    .word_valid (bus.imem_we),
    .word_end   (word_end)
  );

  assign bus.imem_addr = wr_addr;

  // status is masked during reload so the core sees reset in the restart cycle itself
  assign done     = (state == ST_DONE) && !reload;
  assign error    = (state == ST_ERR) && !reload;
  assign core_rst = !done;

`ifdef LOADER_CHECKSUM_EN
  logic [CSUM_WIDTH-1:0] csum;

  assign csum_ok = CSUM_WIDTH'(csum + bus.in_byte) == '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (reload) begin
      csum <= '0;
    end else if (accept) begin
      csum <= csum + bus.in_byte;
    end
  end
`else
  assign csum_ok = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LEN_HI;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (reload) begin
      state_next = ST_LEN_HI;
    end else begin
      case (state)
        ST_LEN_HI: if (accept) state_next = ST_LEN_LO;
        ST_LEN_LO: begin
          if (accept) begin
            if (len_now > CAPACITY)    state_next = ST_ERR;
            else if (len_now == 17'd0) state_next = ST_TAIL;
            else                       state_next = ST_DATA;
          end
        end
        ST_DATA:   if (word_end && last_word) state_next = ST_TAIL;
        ST_CSUM:   if (accept) state_next = csum_ok ? ST_DONE : ST_ERR;
        default:   state_next = state;
      endcase
    end
  end

  // wr_addr latches the index of the word just completed; it is shown with the write pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len        <= 16'd0;
      words_done <= 17'd0;
      wr_addr    <= '0;
    end else if (reload) begin
      len        <= 16'd0;
      words_done <= 17'd0;
      wr_addr    <= '0;
    end else begin
      if (accept && (state == ST_LEN_HI)) len[15:8] <= bus.in_byte;
      if (accept && (state == ST_LEN_LO)) len[7:0]  <= bus.in_byte;
      if (word_end) begin
        words_done <= words_done + 17'd1;
        wr_addr    <= words_done[ADDR_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized scoreboard bench for program_loader (honours LOADER_CHECKSUM_EN)
module tb_program_loader;

  localparam int AW  = 10;
  localparam int CAP = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic reload;
  logic core_rst, done, error;

  program_loader_if #(.ADDR_WIDTH(AW)) bus ();

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .reload   (reload),
    .bus      (bus),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] img_words[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // monitor: every write pulse must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (!rst && bus.imem_we) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 32'(bus.imem_addr), 32'(mon_e.addr));
        check("write_data", bus.imem_wdata, mon_e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int waited;
    for (int g = 0; g < gap; g++) begin
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    waited = 0;
    #1;
    while (!bus.in_ready && waited < 16) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: in_ready %0b after 16 cycles, required 1", bus.in_ready);
      bus.in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic do_reload(input bit offer);
    bus.in_valid = offer;
    bus.in_byte  = 8'($urandom);
    reload = 1'b1;
    #1;
    check("reload_in_ready", 32'(bus.in_ready), 0);
    check("reload_done", 32'(done), 0);
    @(negedge clk);
    reload = 1'b0;
    bus.in_valid = 1'b0;
    check("post_reload_core_rst", 32'(core_rst), 1);
    check("post_reload_error", 32'(error), 0);
  endtask

  // n: word count; gap_mode 0 back-to-back, 1 every other cycle, 2 random idles
  // abort >= 0 stops after that many bytes, expecting only the words already complete
  task automatic run_image(input int n, input int gap_mode, input bit fixed,
                           input bit bad_csum, input int abort);
    logic [7:0]  bytes[$];
    logic [7:0]  sum;
    logic [31:0] w;
    wr_t         e;
    bit          ok;
    bit          exp_err;
    int          nb;
    int          gap;
    bytes = {};
    bytes.push_back(8'(n >> 8));
    bytes.push_back(8'(n));
    if (n <= CAP) begin
      for (int i = 0; i < n; i++) begin
        w = fixed ? img_words[i] : $urandom;
        for (int j = 3; j >= 0; j--) bytes.push_back(w[j*8 +: 8]);
        if (abort < 0 || 2 + 4 * (i + 1) <= abort) begin
          e.addr = AW'(i);
          e.data = w;
          exp_q.push_back(e);
        end
      end
      if (CSUM_ON) begin
        sum = 8'd0;
        foreach (bytes[k]) sum = sum + bytes[k];
        sum = 8'd0 - sum;
        if (bad_csum) sum = sum + 8'd1;
        bytes.push_back(sum);
      end
    end
    exp_err = (n > CAP) || (CSUM_ON && bad_csum);
    nb = (n > CAP) ? 2 : bytes.size();
    if (abort >= 0) nb = abort;
    for (int i = 0; i < nb; i++) begin
      if (i == nb - 1) check("early_done", 32'(done), 0);
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      send_byte(bytes[i], gap, ok);
      if (!ok) return;
    end
    if (abort >= 0) return;
    check("final_done", 32'(done), exp_err ? 0 : 1);
    check("final_error", 32'(error), exp_err ? 1 : 0);
    check("final_core_rst", 32'(core_rst), exp_err ? 1 : 0);
    check("final_in_ready", 32'(bus.in_ready), 0);
`ifndef LOADER_CHECKSUM_EN
    if (n > 0 && n <= CAP) check("last_write_with_done", 32'(bus.imem_we), 1);
`endif
    repeat (3) @(negedge clk);
    check("writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    reload = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte = 8'd0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_core_rst", 32'(core_rst), 1);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_imem_we", 32'(bus.imem_we), 0);
    check("rst_imem_addr", 32'(bus.imem_addr), 0);
    check("rst_imem_wdata", bus.imem_wdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    img_words = {32'h12345678, 32'h9ABCDEF0};
    run_image(2, 0, 1'b1, 1'b0, -1);

    do_reload(1'b0);
    run_image(0, 0, 1'b0, 1'b0, -1);

    do_reload(1'b0);
    run_image(16'h0401, 0, 1'b0, 1'b0, -1);
    bus.in_valid = 1'b1;
    #1;
    check("err_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    do_reload(1'b0);
    run_image(1, 0, 1'b0, 1'b0, -1);

    do_reload(1'b0);
    run_image(2, 0, 1'b0, 1'b0, 6);
    do_reload(1'b1);
    repeat (3) @(negedge clk);
    run_image(2, 0, 1'b0, 1'b0, -1);

    img_words = {32'h00000005};
    do_reload(1'b0);
    run_image(1, 0, 1'b1, 1'b0, -1);
    do_reload(1'b0);
    run_image(1, 0, 1'b1, 1'b1, -1);

    do_reload(1'b0);
    run_image(3, 1, 1'b0, 1'b0, -1);

    do_reload(1'b0);
    run_image(3, 0, 1'b0, 1'b0, 5);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_imem_we", 32'(bus.imem_we), 0);
    check("async_rst_imem_wdata", bus.imem_wdata, 0);
    check("async_rst_in_ready", 32'(bus.in_ready), 0);
    check("async_rst_core_rst", 32'(core_rst), 1);
    @(negedge clk);
    rst = 1'b0;
    run_image(2, 2, 1'b0, 1'b0, -1);

    for (int t = 0; t < 24; t++) begin
      int n;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      n = CAP + 1 + int'($urandom_range(0, 200));
      else if (sel == 1) n = 16'hFFFF;
      else               n = int'($urandom_range(0, 6));
      do_reload(1'($urandom));
      if (sel == 2) begin
        run_image(n, 0, 1'b0, 1'b0, int'($urandom_range(0, 2 + 4 * n)));
        do_reload(1'b1);
      end else begin
        run_image(n, int'($urandom_range(0, 2)), 1'b0, 1'($urandom_range(0, 3) == 0), -1);
      end
    end

    do_reload(1'b0);
    run_image(CAP, 0, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader sitting directly upstream of instruction fetch: it receives a program as a byte stream, assembles big-endian 32-bit words, writes them into instruction memory, and holds the processor in reset until the image is complete. On success it releases the core so fetch starts at word address 0; on a malformed image it keeps the core in reset and flags an error.

## Interface
- ADDR_WIDTH, 10: instruction-memory word-address width; capacity 2**ADDR_WIDTH words.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- reload  in  1  synchronous restart of the load sequence.
- in_valid  in  1  byte-stream valid.
- in_byte  in  8  byte-stream data.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe (one cycle per word).
- imem_addr  out  ADDR_WIDTH  word address of the write.
- imem_wdata  out  32  word being written.
- core_rst  out  1  active-high reset to the processor core.
- done  out  1  image loaded, core released.
- error  out  1  image rejected.

## Operation
- Image format: 16-bit word count N (MSB first), then N words of 4 bytes each, MSB first; optional trailing checksum byte (see Configuration).
- Byte accepted when in_valid && in_ready at a clock edge; nothing else consumes bytes.
- States: LEN_HI -> LEN_LO -> DATA -> (CSUM) -> DONE; any state -> ERR on fault.
  - LEN_HI: capture N[15:8]. LEN_LO: capture N[7:0]; if N > 2**ADDR_WIDTH go to ERR; if N == 0 skip DATA.
  - DATA: shift bytes into a 32-bit assembler; on 4th byte issue write, increment word address; after Nth word leave DATA.
  - DONE: core_rst = 0, done = 1, in_ready = 0. ERR: core_rst = 1, error = 1, in_ready = 0.
- in_ready = 1 in LEN_HI, LEN_LO, DATA, CSUM, and 0 while rst or reload is asserted.
- reload (any state, including mid-word): return to LEN_HI, clear byte count, word address, checksum; core_rst = 1, done = 0, error = 0. A byte offered in the reload cycle is not accepted.
- Word addresses run 0..N-1; no wrap (N is bounded by capacity).

## Timing
- Reset values: state LEN_HI, imem_we 0, imem_addr 0, imem_wdata 0, core_rst 1, done 0, error 0, in_ready 0 while rst high.
- Write latency: imem_we high exactly one cycle, in the cycle after the 4th-byte handshake, with imem_addr/imem_wdata valid in that same cycle.
- No back-pressure during DATA: one byte per cycle sustained; a write pulse may coincide with acceptance of the next word's first byte.
- done/core_rst change in the cycle after the final handshake (last data byte, or LEN_LO when N == 0, or checksum byte); with N>0 that cycle also carries the last imem_we.
- rst asserted mid-load: all outputs return to reset values immediately (asynchronous).

## Configuration
- LOADER_CHECKSUM_EN defined: after the last word (or LEN_LO for N == 0) enter CSUM; accept one byte; the 8-bit modular sum of all image bytes including length and checksum must be 0x00, else ERR. done only after a valid checksum.
- Not defined: no CSUM state; DATA (or LEN_LO for N == 0) goes straight to DONE; no checksum logic synthesised.

## Structure
- loader_pkg: state encoding, LEN_BYTES = 2, WORD_BYTES = 4, checksum width constant.
- One sub-module, byte_assembler: 2-bit byte counter plus 32-bit shift register; outputs word and word_valid; cleared by reload.
- Top: FSM, word-count/address counters, checksum accumulator, output registers.

## Test plan
- N = 2, bytes 00 02 12 34 56 78 9A BC DE F0 -> writes 0x12345678 @0, 0x9ABCDEF0 @1; done = 1, core_rst = 0 the cycle after last byte.
- N = 0 (00 00) -> no imem_we; DONE one cycle after second byte (checksum off).
- N = 0x0401 with ADDR_WIDTH = 10 -> ERR after LEN_LO, error = 1, core_rst = 1, in_ready = 0; reload then clean N = 1 image -> done.
- reload after 6 bytes of a 2-word image, byte offered in reload cycle -> not accepted, no further imem_we from old image; fresh image loads from address 0.
- LOADER_CHECKSUM_EN, image 00 01 00 00 00 05 + FA -> done; same with checksum FB -> error.
- in_valid toggling every other cycle across a 3-word image -> identical writes, one imem_we per 4 accepted bytes.
